tag_rx_sched: RTL and testbench
===============================

Name: tag_rx_sched

Overview:
Frame scheduler for the tag RX chain. It watches the front-panel GPIO sync word and qualifies a sync pulse by its minimum hold time. It then sequences one receive frame of NSYMB symbols × NSIG samples, driving the state, sync-enable, trigger and output-mux controls into the tag RX datapath (DDS/downconverter and symbol counter). After a guard interval it re-arms for the next sync.

Parameters:
REG_WIDTH, 12, width of the front-panel GPIO bus
SYNC_PATTERN, 12'h044, GPIO value that signals sync
SYNC_MASK, 12'h0FF, bits of fp_gpio_in compared against SYNC_PATTERN
SYNC_MIN_CYC, 1024, consecutive matching cycles needed to qualify a sync
NSIG, 1024, samples per symbol
NSYMB, 16, symbols per frame
GUARD_CYC, 64, post-frame dead time before re-arming
CNT_WIDTH, 16, width of all internal counters and index outputs

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  scheduler enable; low forces IDLE
fp_gpio_in  in  REG_WIDTH  front-panel GPIO inputs
fp_gpio_ddr  out  REG_WIDTH  GPIO direction; constant all-zero (all inputs)
rx_state  out  2  0=IDLE 1=SYNC 2=RX 3=GUARD
rx_sync_en  out  1  high while in SYNC
rx_trig  out  1  one-cycle pulse on SYNC→RX
rx_out_mux  out  1  high while in RX; selects the baseband output path
rx_valid  out  1  high on every RX-state cycle (sample strobe)
samp_idx  out  CNT_WIDTH  sample index within the symbol, 0..NSIG-1
symb_idx  out  CNT_WIDTH  symbol index, 0..NSYMB-1
frame_done  out  1  one-cycle pulse on RX→GUARD
sync_lost  out  1  one-cycle pulse when an RX frame is aborted

Behaviour:
- match = ((fp_gpio_in & SYNC_MASK) == (SYNC_PATTERN & SYNC_MASK)), evaluated combinationally on the registered GPIO.
- fp_gpio_in is registered through a 2-flop synchroniser before use, so there are 2 cycles of input latency.
- All outputs are registered.
- Reset (reset=0, async): rx_state=0, all counters=0, all pulses and flags=0. fp_gpio_ddr=0 always.
- enable=0 at any cycle: next state is IDLE, counters clear, and no pulses are emitted.
- IDLE: when match=1, go to SYNC with sync_cnt=1.
- SYNC:
  - match=1: sync_cnt increments, saturating at SYNC_MIN_CYC.
  - match=0 with sync_cnt<SYNC_MIN_CYC: glitch; go to IDLE with no trigger.
  - match=0 with sync_cnt==SYNC_MIN_CYC: go to RX and pulse rx_trig in the same cycle the state becomes 2.
  - The frame therefore starts on the falling edge of a qualified sync.
- RX:
  - rx_valid=1 each cycle.
  - samp_idx increments every cycle and wraps from NSIG-1 to 0; on that wrap symb_idx increments.
  - First RX cycle shows samp_idx=0, symb_idx=0.
  - On the cycle showing samp_idx=NSIG-1 and symb_idx=NSYMB-1, the next state is GUARD and frame_done pulses.
  - The frame is exactly NSIG*NSYMB RX cycles.
- Match while in RX: abort. Pulse sync_lost, go to SYNC with sync_cnt=1, clear indices, no frame_done. A new sync must qualify in full again.
- GUARD: count GUARD_CYC cycles, then go to IDLE. Matches are ignored. A sync held across GUARD's end is seen in IDLE and must still meet SYNC_MIN_CYC, counted from IDLE entry.
- Outside RX: samp_idx and symb_idx hold 0 and rx_valid=0.
- Counters never overflow: CNT_WIDTH must cover SYNC_MIN_CYC, NSIG, NSYMB and GUARD_CYC.

Test Plan:
All scenarios use SYNC_MIN_CYC=8, NSIG=4, NSYMB=2, GUARD_CYC=3.
- Reset/idle: reset=0 for 10 cycles, fp_gpio_in=0 → rx_state=0, fp_gpio_ddr=0, all pulses 0. Assert reset=0 mid-RX → outputs return to 0 immediately.
- Nominal frame: fp_gpio_in=12'h044 for 20 cycles, then 12'h000 → rx_trig pulses once, then 8 rx_valid cycles. (samp_idx, symb_idx) run (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1). frame_done pulses once, GUARD lasts 3 cycles, then IDLE.
- Glitch rejection: 12'h044 for 5 cycles, then 0 → SYNC→IDLE, no rx_trig. Also 12'h0C4 (masked mismatch) → stays IDLE. 12'h144 (unmasked bit differs) → treated as match.
- Abort: qualified sync, then 12'h044 reasserted at RX sample 3 → sync_lost pulse, rx_state=1, no frame_done. Holding 8+ cycles and releasing → a new full frame runs.
- Back-to-back: sync held through GUARD → no re-trigger in GUARD. The next frame starts only after 8 matching cycles counted from IDLE entry, then release.
- Enable: drop enable mid-RX → IDLE on the next cycle, no frame_done or sync_lost, indices 0.

Source files
------------

// File: rtl/tag_rx_sched.sv
// Frame scheduler for the tag RX chain. It qualifies a front-panel sync word by hold time,
// then sequences one NSYMB x NSIG receive frame followed by a guard interval.
module tag_rx_sched #(
    parameter int                   REG_WIDTH    = 12,
    parameter logic [REG_WIDTH-1:0] SYNC_PATTERN = 12'h044,
    parameter logic [REG_WIDTH-1:0] SYNC_MASK    = 12'h0FF,
    parameter int                   SYNC_MIN_CYC = 1024,
    parameter int                   NSIG         = 1024,
    parameter int                   NSYMB        = 16,
    parameter int                   GUARD_CYC    = 64,
    parameter int                   CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [REG_WIDTH-1:0] fp_gpio_in,
    output logic [REG_WIDTH-1:0] fp_gpio_ddr,
    output logic [1:0]           rx_state,
    output logic                 rx_sync_en,
    output logic                 rx_trig,
    output logic                 rx_out_mux,
    output logic                 rx_valid,
    output logic [CNT_WIDTH-1:0] samp_idx,
    output logic [CNT_WIDTH-1:0] symb_idx,
    output logic                 frame_done,
    output logic                 sync_lost
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_RX    = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SYNC_MAX   = CNT_WIDTH'(SYNC_MIN_CYC);
    localparam logic [CNT_WIDTH-1:0] SAMP_LAST  = CNT_WIDTH'(NSIG - 1);
    localparam logic [CNT_WIDTH-1:0] SYMB_LAST  = CNT_WIDTH'(NSYMB - 1);
    localparam logic [CNT_WIDTH-1:0] GUARD_LAST = CNT_WIDTH'(GUARD_CYC - 1);

    state_t               state;
    state_t               state_next;
    logic [REG_WIDTH-1:0] gpio_meta;
    logic [REG_WIDTH-1:0] gpio_sync;
    logic                 match;
    logic [CNT_WIDTH-1:0] sync_cnt;
    logic [CNT_WIDTH-1:0] sync_cnt_next;
    logic [CNT_WIDTH-1:0] guard_cnt;
    logic [CNT_WIDTH-1:0] guard_cnt_next;
    logic [CNT_WIDTH-1:0] samp_next;
    logic [CNT_WIDTH-1:0] symb_next;
    logic                 trig_next;
    logic                 done_next;
    logic                 lost_next;

    assign fp_gpio_ddr = '0;
    assign rx_state    = state;
    assign match       = ((gpio_sync & SYNC_MASK) == (SYNC_PATTERN & SYNC_MASK));

    // The GPIO pins are asynchronous to clk, so only the second flop is ever compared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_meta <= '0;
            gpio_sync <= '0;
        end else begin
            gpio_meta <= fp_gpio_in;
            gpio_sync <= gpio_meta;
        end
    end

    always_comb begin
        state_next     = state;
        sync_cnt_next  = '0;
        guard_cnt_next = '0;
        samp_next      = '0;
        symb_next      = '0;
        trig_next      = 1'b0;
        done_next      = 1'b0;
        lost_next      = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match) begin
                        state_next    = ST_SYNC;
                        sync_cnt_next = ONE;
                    end
                end
                ST_SYNC: begin
                    // The frame starts on the falling edge of a sync that was held long enough.
                    if (match) begin
                        sync_cnt_next = (sync_cnt == SYNC_MAX) ? sync_cnt : sync_cnt + ONE;
                    end else if (sync_cnt == SYNC_MAX) begin
                        state_next = ST_RX;
                        trig_next  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_RX: begin
                    if (match) begin
                        state_next    = ST_SYNC;
                        sync_cnt_next = ONE;
                        lost_next     = 1'b1;
                    end else if (samp_idx == SAMP_LAST && symb_idx == SYMB_LAST) begin
                        state_next = ST_GUARD;
                        done_next  = 1'b1;
                    end else if (samp_idx == SAMP_LAST) begin
                        symb_next = symb_idx + ONE;
                    end else begin
                        samp_next = samp_idx + ONE;
                        symb_next = symb_idx;
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        guard_cnt_next = guard_cnt + ONE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Status flags are derived from the next state so they line up with rx_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            sync_cnt   <= '0;
            guard_cnt  <= '0;
            samp_idx   <= '0;
            symb_idx   <= '0;
            rx_trig    <= 1'b0;
            frame_done <= 1'b0;
            sync_lost  <= 1'b0;
            rx_sync_en <= 1'b0;
            rx_out_mux <= 1'b0;
            rx_valid   <= 1'b0;
        end else begin
            state      <= state_next;
            sync_cnt   <= sync_cnt_next;
            guard_cnt  <= guard_cnt_next;
            samp_idx   <= samp_next;
            symb_idx   <= symb_next;
            rx_trig    <= trig_next;
            frame_done <= done_next;
            sync_lost  <= lost_next;
            rx_sync_en <= (state_next == ST_SYNC);
            rx_out_mux <= (state_next == ST_RX);
            rx_valid   <= (state_next == ST_RX);
        end
    end

endmodule

// File: tb/tb_tag_rx_sched.sv
// Self-checking bench for tag_rx_sched: directed scenarios plus random GPIO/enable segments,
// every cycle compared against a frame-position reference model.
module tb_tag_rx_sched;

    localparam int REG_WIDTH    = 12;
    localparam int SYNC_MIN_CYC = 8;
    localparam int NSIG         = 4;
    localparam int NSYMB        = 2;
    localparam int GUARD_CYC    = 3;
    localparam int CNT_WIDTH    = 16;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic [REG_WIDTH-1:0] fp_gpio_in;
    logic [REG_WIDTH-1:0] fp_gpio_ddr;
    logic [1:0]           rx_state;
    logic                 rx_sync_en;
    logic                 rx_trig;
    logic                 rx_out_mux;
    logic                 rx_valid;
    logic [CNT_WIDTH-1:0] samp_idx;
    logic [CNT_WIDTH-1:0] symb_idx;
    logic                 frame_done;
    logic                 sync_lost;

    tag_rx_sched #(
        .REG_WIDTH   (REG_WIDTH),
        .SYNC_PATTERN(12'h044),
        .SYNC_MASK   (12'h0FF),
        .SYNC_MIN_CYC(SYNC_MIN_CYC),
        .NSIG        (NSIG),
        .NSYMB       (NSYMB),
        .GUARD_CYC   (GUARD_CYC),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fp_gpio_in (fp_gpio_in),
        .fp_gpio_ddr(fp_gpio_ddr),
        .rx_state   (rx_state),
        .rx_sync_en (rx_sync_en),
        .rx_trig    (rx_trig),
        .rx_out_mux (rx_out_mux),
        .rx_valid   (rx_valid),
        .samp_idx   (samp_idx),
        .symb_idx   (symb_idx),
        .frame_done (frame_done),
        .sync_lost  (sync_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: mode, run length of matches, position within the frame, guard time spent.
    int             mState;
    int             mRun;
    int             mPos;
    int             mElapsed;
    logic [11:0]    mPipe0;
    logic [11:0]    mPipe1;
    bit             mTrig;
    bit             mDone;
    bit             mLost;

    int trigSeen;
    int doneSeen;
    int lostSeen;
    int validSeen;
    int syncEnSeen;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic modelReset();
        mState = 0; mRun = 0; mPos = 0; mElapsed = 0;
        mPipe0 = '0; mPipe1 = '0;
        mTrig = 0; mDone = 0; mLost = 0;
    endtask

    task automatic modelStep(input logic [11:0] gpio, input bit en);
        bit m;
        m = ((mPipe1 & 12'h0FF) == 12'h044);
        mPipe1 = mPipe0;
        mPipe0 = gpio;
        mTrig = 0; mDone = 0; mLost = 0;
        if (!en) begin
            mState = 0; mRun = 0; mPos = 0; mElapsed = 0;
        end else begin
            case (mState)
                0: if (m) begin mState = 1; mRun = 1; end
                1: begin
                    if (m) mRun = (mRun < SYNC_MIN_CYC) ? mRun + 1 : SYNC_MIN_CYC;
                    else if (mRun >= SYNC_MIN_CYC) begin mState = 2; mPos = 0; mTrig = 1; end
                    else begin mState = 0; mRun = 0; end
                end
                2: begin
                    if (m) begin mLost = 1; mState = 1; mRun = 1; mPos = 0; end
                    else if (mPos == NSIG * NSYMB - 1) begin mDone = 1; mState = 3; mElapsed = 0; mPos = 0; end
                    else mPos++;
                end
                default: begin
                    mElapsed++;
                    if (mElapsed == GUARD_CYC) mState = 0;
                end
            endcase
        end
    endtask

    task automatic checkAll();
        bit inRx;
        inRx = (mState == 2);
        checkOutput("rx_state",   32'(rx_state),    32'(mState));
        checkOutput("rx_sync_en", 32'(rx_sync_en),  32'(mState == 1));
        checkOutput("rx_trig",    32'(rx_trig),     32'(mTrig));
        checkOutput("rx_out_mux", 32'(rx_out_mux),  32'(inRx));
        checkOutput("rx_valid",   32'(rx_valid),    32'(inRx));
        checkOutput("samp_idx",   32'(samp_idx),    inRx ? 32'(mPos % NSIG) : 32'd0);
        checkOutput("symb_idx",   32'(symb_idx),    inRx ? 32'(mPos / NSIG) : 32'd0);
        checkOutput("frame_done", 32'(frame_done),  32'(mDone));
        checkOutput("sync_lost",  32'(sync_lost),   32'(mLost));
        checkOutput("gpio_ddr",   32'(fp_gpio_ddr), 32'd0);
    endtask

    task automatic clearCounts();
        trigSeen = 0; doneSeen = 0; lostSeen = 0; validSeen = 0; syncEnSeen = 0;
    endtask

    task automatic applyStimulus(input logic [11:0] gpio, input bit en, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            fp_gpio_in = gpio;
            enable     = en;
            @(posedge clk);
            #1;
            if (!reset) modelReset();
            else modelStep(gpio, en);
            checkAll();
            trigSeen   += int'(rx_trig);
            doneSeen   += int'(frame_done);
            lostSeen   += int'(sync_lost);
            validSeen  += int'(rx_valid);
            syncEnSeen += int'(rx_sync_en);
        end
    endtask

    initial begin
        logic [11:0] g;
        bit          en;
        reset      = 1'b1;
        enable     = 1'b1;
        fp_gpio_in = '0;
        modelReset();
        clearCounts();
        #1 reset = 1'b0;

        applyStimulus(12'h000, 1, 10);
        reset = 1'b1;

        $display("[TB] nominal frame");
        clearCounts();
        applyStimulus(12'h044, 1, 20);
        applyStimulus(12'h000, 1, 20);
        checkOutput("nom_trig",  32'(trigSeen),  32'd1);
        checkOutput("nom_valid", 32'(validSeen), 32'd8);
        checkOutput("nom_done",  32'(doneSeen),  32'd1);
        checkOutput("nom_lost",  32'(lostSeen),  32'd0);
        checkOutput("nom_idle",  32'(rx_state),  32'd0);

        $display("[TB] glitch and mask");
        clearCounts();
        applyStimulus(12'h044, 1, 5);
        applyStimulus(12'h000, 1, 10);
        checkOutput("glitch_trig", 32'(trigSeen),   32'd0);
        checkOutput("glitch_sync", 32'(syncEnSeen), 32'd5);
        clearCounts();
        applyStimulus(12'h0C4, 1, 12);
        checkOutput("masked_sync", 32'(syncEnSeen), 32'd0);
        applyStimulus(12'h144, 1, 12);
        applyStimulus(12'h000, 1, 15);
        checkOutput("unmasked_trig", 32'(trigSeen), 32'd1);
        checkOutput("unmasked_done", 32'(doneSeen), 32'd1);

        $display("[TB] abort");
        clearCounts();
        applyStimulus(12'h044, 1, 12);
        applyStimulus(12'h000, 1, 4);
        applyStimulus(12'h044, 1, 3);
        checkOutput("abort_state", 32'(rx_state),  32'd1);
        checkOutput("abort_lost",  32'(sync_lost), 32'd1);
        checkOutput("abort_done",  32'(doneSeen),  32'd0);
        applyStimulus(12'h044, 1, 10);
        applyStimulus(12'h000, 1, 20);
        checkOutput("refr_trig", 32'(trigSeen), 32'd2);
        checkOutput("refr_done", 32'(doneSeen), 32'd1);
        checkOutput("refr_lost", 32'(lostSeen), 32'd1);

        $display("[TB] back-to-back");
        clearCounts();
        applyStimulus(12'h044, 1, 12);
        applyStimulus(12'h000, 1, 9);
        applyStimulus(12'h044, 1, 20);
        applyStimulus(12'h000, 1, 20);
        checkOutput("b2b_trig", 32'(trigSeen), 32'd2);
        checkOutput("b2b_done", 32'(doneSeen), 32'd2);
        clearCounts();
        applyStimulus(12'h044, 1, 12);
        applyStimulus(12'h000, 1, 9);
        applyStimulus(12'h044, 1, 10);
        applyStimulus(12'h000, 1, 20);
        checkOutput("short_trig", 32'(trigSeen), 32'd1);

        $display("[TB] enable drop");
        clearCounts();
        applyStimulus(12'h044, 1, 12);
        applyStimulus(12'h000, 1, 5);
        applyStimulus(12'h000, 0, 1);
        checkOutput("en_state", 32'(rx_state), 32'd0);
        checkOutput("en_samp",  32'(samp_idx), 32'd0);
        applyStimulus(12'h000, 1, 10);
        checkOutput("en_done", 32'(doneSeen), 32'd0);
        checkOutput("en_lost", 32'(lostSeen), 32'd0);

        $display("[TB] async reset mid-RX");
        applyStimulus(12'h044, 1, 12);
        applyStimulus(12'h000, 1, 6);
        reset = 1'b0;
        #1;
        checkOutput("rst_state", 32'(rx_state),   32'd0);
        checkOutput("rst_valid", 32'(rx_valid),   32'd0);
        checkOutput("rst_mux",   32'(rx_out_mux), 32'd0);
        checkOutput("rst_samp",  32'(samp_idx),   32'd0);
        modelReset();
        applyStimulus(12'h044, 1, 3);
        reset = 1'b1;
        modelReset();

        $display("[TB] random segments");
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: g = 12'h044;
                1: g = 12'h144;
                2: g = 12'h0C4;
                3: g = 12'h000;
                default: g = 12'($urandom);
            endcase
            en = ($urandom_range(0, 15) != 0);
            applyStimulus(g, en, int'($urandom_range(1, 14)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
